iq_rx_deframer: RTL and testbench

- Upstream feeder of the 0.9 GHz and 2.4 GHz RX FIFOs that the SMI controller drains.
- Takes the RF transceiver's I/Q LVDS stream, already split into one 2-bit pair per i_sys_clk, and finds frame sync.
- Assembles each 32-bit I/Q frame and pushes it into the RX FIFO write port.
- One instance is used per band.

---
 rtl/iq_rx_pkg.sv | 25 ++
 rtl/sat_counter.sv | 22 ++
 rtl/iq_rx_deframer.sv | 156 +++++++++++++++
 tb/tb_iq_rx_deframer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/iq_rx_pkg.sv
// iq_rx_pkg: shared constants for the RX I/Q deframer.
// Frame layout, sync patterns and deframer state encoding.
package iq_rx_pkg;

   localparam logic [1:0] I_SYNC = 2'b10;
   localparam logic [1:0] Q_SYNC = 2'b01;

   localparam int PAIRS_PER_FRAME = 16;
   localparam int Q_SYNC_PAIR     = 8;

   localparam logic [3:0] LAST_PAIR   = 4'(PAIRS_PER_FRAME - 1);
   localparam logic [3:0] Q_PAIR      = 4'(Q_SYNC_PAIR);
   localparam logic [3:0] I_LAST_PAIR = 4'(Q_SYNC_PAIR - 1);

   localparam logic [1:0] ST_HUNT = 2'd0;
   localparam logic [1:0] ST_I    = 2'd1;
   localparam logic [1:0] ST_Q    = 2'd2;
   localparam logic [1:0] ST_NEXT = 2'd3;

   // Bit position of the MSB of pair idx within the 32-bit frame word.
   function automatic logic [4:0] pair_msb(input logic [3:0] idx);
      return 5'd31 - {idx, 1'b0};
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Clear has priority over increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         i_sys_clk,
   input  logic         i_reset,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] count
);

   // Count up to all-ones and stick there; clear beats increment.
   always_ff @(posedge i_sys_clk) begin
      if (i_reset || clear) begin
         count <= '0;
      end else if (inc && !(&count)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/iq_rx_deframer.sv
// iq_rx_deframer: finds I/Q frame sync in a 2-bit-per-clock stream,
// assembles 32-bit frames and pushes locked frames into the RX FIFO.
module iq_rx_deframer
   import iq_rx_pkg::*;
#(
   parameter int LOCK_FRAMES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             i_sys_clk,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic [1:0]       i_ddr_data,
   output logic             o_fifo_push,
   output logic [31:0]      o_fifo_data,
   input  logic             i_fifo_full,
   output logic             o_locked,
   input  logic             i_clear_cnt,
   output logic [CNT_W-1:0] o_sync_err_cnt,
   output logic [CNT_W-1:0] o_overflow_cnt
);

   localparam int GW = $clog2(LOCK_FRAMES + 1);
   localparam logic [GW-1:0] LOCK_V = GW'(LOCK_FRAMES);

   logic [1:0]    state, state_nx;
   logic [3:0]    pair_cnt, pair_nx;
   logic [31:0]   word, word_nx;
   logic [GW-1:0] good_cnt, good_nx, good_inc;
   logic          locked_nx;
   logic          push_nx;
   logic [31:0]   data_nx;
   logic          sync_err;
   logic          ovf_inc;
   logic [4:0]    msb;

   assign msb      = pair_msb(pair_cnt);
   assign good_inc = (good_cnt == LOCK_V) ? LOCK_V : good_cnt + 1'b1;

   // Next-state, frame assembly, lock and push decisions.
   always_comb begin
      state_nx  = state;
      pair_nx   = pair_cnt;
      word_nx   = word;
      good_nx   = good_cnt;
      locked_nx = o_locked;
      push_nx   = 1'b0;
      data_nx   = o_fifo_data;
      sync_err  = 1'b0;
      ovf_inc   = 1'b0;
      if (!i_enable) begin
         state_nx  = ST_HUNT;
         pair_nx   = '0;
         good_nx   = '0;
         locked_nx = 1'b0;
      end else begin
         case (state)
            ST_HUNT: begin
               if (i_ddr_data == I_SYNC) begin
                  word_nx  = {I_SYNC, 30'd0};
                  pair_nx  = 4'd1;
                  state_nx = ST_I;
               end
            end
            ST_I: begin
               word_nx[msb -: 2] = i_ddr_data;
               pair_nx = pair_cnt + 4'd1;
               if (pair_cnt == I_LAST_PAIR) begin
                  state_nx = ST_Q;
               end
            end
            ST_Q: begin
               if (pair_cnt == Q_PAIR && i_ddr_data != Q_SYNC) begin
                  sync_err  = 1'b1;
                  locked_nx = 1'b0;
                  good_nx   = '0;
                  pair_nx   = '0;
                  state_nx  = ST_HUNT;
               end else begin
                  word_nx[msb -: 2] = i_ddr_data;
                  if (pair_cnt == LAST_PAIR) begin
                     good_nx   = good_inc;
                     locked_nx = (good_inc == LOCK_V);
                     pair_nx   = '0;
                     state_nx  = ST_NEXT;
                     if (good_inc == LOCK_V) begin
                        if (i_fifo_full) begin
                           ovf_inc = 1'b1;
                        end else begin
                           push_nx = 1'b1;
                           data_nx = word_nx;
                        end
                     end
                  end else begin
                     pair_nx = pair_cnt + 4'd1;
                  end
               end
            end
            ST_NEXT: begin
               if (i_ddr_data == I_SYNC) begin
                  word_nx  = {I_SYNC, 30'd0};
                  pair_nx  = 4'd1;
                  state_nx = ST_I;
               end else begin
                  sync_err  = 1'b1;
                  locked_nx = 1'b0;
                  good_nx   = '0;
                  pair_nx   = '0;
                  state_nx  = ST_HUNT;
               end
            end
            default: begin
               state_nx = ST_HUNT;
               pair_nx  = '0;
            end
         endcase
      end
   end

   // Register deframer state and the FIFO write port.
   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         state       <= ST_HUNT;
         pair_cnt    <= '0;
         word        <= '0;
         good_cnt    <= '0;
         o_locked    <= 1'b0;
         o_fifo_push <= 1'b0;
         o_fifo_data <= '0;
      end else begin
         state       <= state_nx;
         pair_cnt    <= pair_nx;
         word        <= word_nx;
         good_cnt    <= good_nx;
         o_locked    <= locked_nx;
         o_fifo_push <= push_nx;
         o_fifo_data <= data_nx;
      end
   end

   sat_counter #(.W(CNT_W)) u_sync_err_cnt (
      .i_sys_clk (i_sys_clk),
      .i_reset   (i_reset),
      .inc       (sync_err),
      .clear     (i_clear_cnt),
      .count     (o_sync_err_cnt)
   );

   sat_counter #(.W(CNT_W)) u_overflow_cnt (
      .i_sys_clk (i_sys_clk),
      .i_reset   (i_reset),
      .inc       (ovf_inc),
      .clear     (i_clear_cnt),
      .count     (o_overflow_cnt)
   );

endmodule

// File: tb/tb_iq_rx_deframer.sv
// tb_iq_rx_deframer: directed per-cycle vector bench for the deframer.
// Each vector holds one cycle of inputs and the outputs expected after it.
module tb_iq_rx_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  ddr;
  logic        push;
  logic [31:0] data;
  logic        full;
  logic        locked;
  logic        clr;
  logic [7:0]  serr;
  logic [7:0]  ovf;
  logic        done = 1'b0;

  always #5 clk = ~clk;

  iq_rx_deframer #(.LOCK_FRAMES(2), .CNT_W(8)) dut (
    .i_sys_clk      (clk),
    .i_reset        (rst),
    .i_enable       (en),
    .i_ddr_data     (ddr),
    .o_fifo_push    (push),
    .o_fifo_data    (data),
    .i_fifo_full    (full),
    .o_locked       (locked),
    .i_clear_cnt    (clr),
    .o_sync_err_cnt (serr),
    .o_overflow_cnt (ovf)
  );

  typedef struct {
    string       tag;
    logic [1:0]  pair;
    logic        en;
    logic        full;
    logic        clr;
    logic        rst;
    logic        push;
    logic [31:0] data;
    logic        lock;
    logic [7:0]  serr;
    logic [7:0]  ovf;
  } vec_t;

  vec_t vq[$];

  logic       cur_lock;
  logic [7:0] cur_serr;
  logic [7:0] cur_ovf;
  int         n_vec;
  int         n_bad;

  localparam logic [31:0] W1 = 32'hA4684ACF;
  localparam logic [31:0] W2 = 32'hBFFF4000;
  localparam logic [31:0] W3 = 32'h95546AAB;

  task automatic put(input string tag, input logic [1:0] p,
                     input logic e, input logic f, input logic c,
                     input logic r, input logic ps,
                     input logic [31:0] d);
    vec_t v;
    v.tag  = tag;
    v.pair = p;
    v.en   = e;
    v.full = f;
    v.clr  = c;
    v.rst  = r;
    v.push = ps;
    v.data = d;
    v.lock = cur_lock;
    v.serr = cur_serr;
    v.ovf  = cur_ovf;
    vq.push_back(v);
  endtask

  task automatic partial(input string tag, input logic [31:0] w,
                         input int n);
    for (int k = 0; k < n; k++) begin
      put(tag, w[31-2*k -: 2], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic frame(input string tag, input logic [31:0] w,
                       input logic f, input logic lock_after,
                       input logic ps, input logic [7:0] ovf_after);
    partial(tag, w, 15);
    cur_lock = lock_after;
    cur_ovf  = ovf_after;
    put(tag, w[1:0], 1'b1, f, 1'b0, 1'b0, ps, w);
  endtask

  task automatic sync_fail(input string tag, input logic c,
                           input logic [7:0] serr_after);
    put(tag, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 7; k++) begin
      put(tag, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
    cur_lock = 1'b0;
    cur_serr = serr_after;
    if (c) cur_ovf = 8'd0;
    put(tag, 2'b11, 1'b1, 1'b0, c, 1'b0, 1'b0, '0);
  endtask

  task automatic build();
    logic [1:0] hunt_g[6];
    logic [1:0] fake_g[7];
    hunt_g = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b11};
    fake_g = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b11};
    cur_lock = 1'b0;
    cur_serr = 8'd0;
    cur_ovf  = 8'd0;

    put("reset", 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    put("reset", 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    put("disabled", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    put("disabled", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    frame("basic_f1", W1, 1'b0, 1'b0, 1'b0, 8'd0);
    frame("basic_f2", W1, 1'b0, 1'b1, 1'b1, 8'd0);
    frame("basic_f3", W1, 1'b0, 1'b1, 1'b1, 8'd0);

    partial("badq", W1, 8);
    cur_lock = 1'b0;
    cur_serr = 8'd1;
    put("badq_p8", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    frame("relock_f1", W2, 1'b0, 1'b0, 1'b0, 8'd0);
    frame("relock_f2", W2, 1'b0, 1'b1, 1'b1, 8'd0);

    cur_lock = 1'b0;
    cur_serr = 8'd2;
    put("next_bad", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    foreach (hunt_g[k]) begin
      put("hunt", hunt_g[k], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
    put("fake_sync", 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    foreach (fake_g[k]) begin
      put("fake_i", fake_g[k], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
    cur_serr = 8'd3;
    put("fake_q", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    put("hunt", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    put("hunt", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    frame("garb_f1", W3, 1'b0, 1'b0, 1'b0, 8'd0);
    frame("garb_f2", W3, 1'b0, 1'b1, 1'b1, 8'd0);

    frame("full_1", W1, 1'b1, 1'b1, 1'b0, 8'd1);
    frame("full_2", W1, 1'b1, 1'b1, 1'b0, 8'd2);
    frame("full_3", W1, 1'b1, 1'b1, 1'b0, 8'd3);
    frame("full_off", W1, 1'b0, 1'b1, 1'b1, 8'd3);

    partial("en_drop", W1, 5);
    cur_lock = 1'b0;
    put("en_low", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    frame("en_f1", W2, 1'b0, 1'b0, 1'b0, 8'd3);
    frame("en_f2", W2, 1'b0, 1'b1, 1'b1, 8'd3);

    partial("rst_mid", W2, 12);
    cur_lock = 1'b0;
    cur_serr = 8'd0;
    cur_ovf  = 8'd0;
    put("rst_p12", 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    frame("rst_f1", W1, 1'b0, 1'b0, 1'b0, 8'd0);
    frame("rst_f2", W1, 1'b0, 1'b1, 1'b1, 8'd0);

    frame("ovf_pre", W1, 1'b1, 1'b1, 1'b0, 8'd1);
    for (int i = 1; i <= 300; i++) begin
      sync_fail("sat", 1'b0, (i >= 255) ? 8'hFF : 8'(i));
    end
    sync_fail("clr_err", 1'b1, 8'd0);
    put("hunt_end", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #200us;
    if (!done) begin
      $display("FAIL timeout: vector run did not finish");
      $finish;
    end
  end

  initial begin
    vec_t v;
    logic bad;
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    en    = 1'b0;
    ddr   = 2'b00;
    full  = 1'b0;
    clr   = 1'b0;
    @(posedge clk);
    #1;
    if (push !== 1'b0 || data !== 32'd0 || locked !== 1'b0 ||
        serr !== 8'd0 || ovf !== 8'd0) begin
      n_bad++;
      $display("FAIL reset state: push=%b data=%h lock=%b serr=%0d ovf=%0d",
               push, data, locked, serr, ovf);
    end
    build();
    for (int i = 0; i < vq.size(); i++) begin
      v    = vq[i];
      ddr  = v.pair;
      en   = v.en;
      full = v.full;
      clr  = v.clr;
      rst  = v.rst;
      @(posedge clk);
      #1;
      n_vec++;
      bad = (push !== v.push) || (locked !== v.lock) ||
            (serr !== v.serr) || (ovf !== v.ovf) ||
            ((v.push || v.rst) && data !== v.data);
      if (bad) begin
        n_bad++;
        $display("FAIL %s vec %0d: got push=%b lock=%b serr=%0d ovf=%0d data=%h, want push=%b lock=%b serr=%0d ovf=%0d data=%h",
                 v.tag, i, push, locked, serr, ovf, data,
                 v.push, v.lock, v.serr, v.ovf, v.data);
      end
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad != 0) begin
      $display("FAIL: %0d miscompares", n_bad);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule
